// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: processor data-bus view (address, write data/enable, read data) of the display driver.
interface seven_seg_scanner_if;
    logic [11:0] A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    modport master (output A, output WD, output WE, input RD);
    modport slave (input A, input WD, input WE, output RD);
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: memory-mapped 4-digit multiplexed seven-segment driver (VALUE/CTRL/RAW registers).
// Optional raw segment mode (RAW register, CTRL[8]) is built only with SEVSEG_RAW_MODE_EN defined.
module seven_seg_scanner #(
    parameter logic [11:0] BASE_ADDR    = 12'hF00,
    parameter int          REFRESH_DIV  = 100000,
    parameter int          BLANK_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_scanner_if.slave  bus,
    output logic [6:0]          hex,
    output logic                hex_dot,
    output logic [3:0]          hex_sel
);
`ifdef SEVSEG_RAW_MODE_EN
    localparam int CTRL_W = 9;
`else
    localparam int CTRL_W = 8;
`endif
    localparam int              CW    = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK = CW'(BLANK_CYCLES);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [15:0]       value_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        dig_q, dig_d;
    logic [6:0]        hex_q, hex_d;
    logic              dot_q, dot_d;
    logic [3:0]        sel_q, sel_d;
    logic              hit_v, hit_c, hit_r;
    logic [31:0]       rd_raw;
    logic [6:0]        seg;

    assign hit_v = bus.A == BASE_ADDR;
    assign hit_c = bus.A == BASE_ADDR + 12'd4;

`ifdef SEVSEG_RAW_MODE_EN
    logic [31:0] raw_q;
    assign hit_r  = bus.A == BASE_ADDR + 12'd8;
    assign rd_raw = hit_r ? raw_q : 32'h0;
    assign seg    = ctrl_q[8] ? ~raw_q[{dig_q, 3'b000} +: 7] : SEG_LUT[value_q[{dig_q, 2'b00} +: 4]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) raw_q <= '0;
        else if (bus.WE && hit_r) raw_q <= bus.WD;
    end
`else
    logic unused_wd;
    assign hit_r     = 1'b0;
    assign rd_raw    = 32'h0;
    assign seg       = SEG_LUT[value_q[{dig_q, 2'b00} +: 4]];
    assign unused_wd = ^{bus.WD[31:16], hit_r};
`endif

    assign bus.RD = hit_v ? {16'h0, value_q} :
                    hit_c ? {{(32-CTRL_W){1'b0}}, ctrl_q} : rd_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            ctrl_q  <= CTRL_W'(9'h0F0);
        end else begin
            if (bus.WE && hit_v) value_q <= bus.WD[15:0];
            if (bus.WE && hit_c) ctrl_q <= bus.WD[CTRL_W-1:0];
        end
    end

    // Scan counters free-run; bus traffic never stalls them.
    always_comb begin
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        dig_d = cnt_q == LAST ? dig_q + 2'd1 : dig_q;
    end

    always_comb begin
        hex_d = 7'h7F;
        dot_d = 1'b1;
        sel_d = 4'hF;
        if (cnt_q >= BLANK && ctrl_q[7:4][dig_q]) begin
            hex_d = seg;
            dot_d = ~ctrl_q[3:0][dig_q];
            sel_d = ~(4'b0001 << dig_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dig_q <= '0;
            hex_q <= 7'h7F;
            dot_q <= 1'b1;
            sel_q <= 4'hF;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
            hex_q <= hex_d;
            dot_q <= dot_d;
            sel_q <= sel_d;
        end
    end

    assign hex     = hex_q;
    assign hex_dot = dot_q;
    assign hex_sel = sel_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed stimulus with a cycle-index display model checked every cycle.
module tb_seven_seg_scanner;
    localparam int          DIV  = 8;
    localparam int          BLK  = 2;
    localparam logic [11:0] BASE = 12'hF00;
`ifdef SEVSEG_RAW_MODE_EN
    localparam bit RAW_EN = 1'b1;
`else
    localparam bit RAW_EN = 1'b0;
`endif
    localparam logic [6:0] LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] hex;
    logic       hex_dot;
    logic [3:0] hex_sel;
    int         checks = 0;
    int         errors = 0;

    seven_seg_scanner_if bus();

    seven_seg_scanner #(.BASE_ADDR(BASE), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .hex(hex), .hex_dot(hex_dot), .hex_sel(hex_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edge k after reset release shows the slot state reached after k edges, using registers as they stood before edge k.
    logic [15:0] m_val  = '0;
    logic [8:0]  m_ctrl = 9'h0F0;
    logic [31:0] m_raw  = '0;
    logic [11:0] m_exp  = 12'hFFF;
    int          k = 0;
    int          mc, md;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val = '0; m_ctrl = 9'h0F0; m_raw = '0; m_exp = 12'hFFF; k = 0;
        end else begin
            mc = k % DIV;
            md = (k / DIV) % 4;
            if (mc < BLK || !m_ctrl[4+md]) m_exp = 12'hFFF;
            else begin
                m_exp[3:0]  = ~(4'b0001 << md);
                m_exp[4]    = ~m_ctrl[md];
                m_exp[11:5] = (RAW_EN && m_ctrl[8]) ? ~m_raw[8*md +: 7] : LUT[m_val[4*md +: 4]];
            end
            k++;
            if (bus.WE) begin
                if (bus.A == BASE) m_val = bus.WD[15:0];
                if (bus.A == BASE + 12'd4) m_ctrl = RAW_EN ? bus.WD[8:0] : {1'b0, bus.WD[7:0]};
                if (RAW_EN && bus.A == BASE + 12'd8) m_raw = bus.WD;
            end
        end
    end

    always @(negedge clk) chk("scan", {20'h0, hex, hex_dot, hex_sel}, {20'h0, m_exp});

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.A = a; bus.WD = d; bus.WE = 1'b1;
        @(negedge clk);
        bus.WE = 1'b0; bus.A = 12'h000;
    endtask

    task automatic rd(input string n, input logic [11:0] a, input logic [31:0] e);
        bus.A = a;
        #1;
        chk(n, bus.RD, e);
    endtask

    // Observe one full scan starting at digit 0, slot start; tally lit cycles per digit.
    task automatic sweep(input string n, input logic [3:0] en, input logic [6:0] h0, h1, h2, h3,
                         input logic [3:0] dots);
        logic [6:0] h [4];
        int lit [4];
        int bad;
        h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
        bad = 0;
        for (int d = 0; d < 4; d++) lit[d] = 0;
        @(negedge clk);
        for (int i = 0; i < 64 && (k % 32) != 1; i++) @(negedge clk);
        chk({n, " align"}, k % 32, 1);
        for (int i = 0; i < 32; i++) begin
            if (hex_sel == 4'hF) begin
                if (hex != 7'h7F || hex_dot != 1'b1) bad++;
            end else begin
                for (int d = 0; d < 4; d++)
                    if (hex_sel == ~(4'b0001 << d)) begin
                        lit[d]++;
                        if (hex != h[d] || hex_dot != ~dots[d]) bad++;
                    end
            end
            @(negedge clk);
        end
        for (int d = 0; d < 4; d++) chk($sformatf("%s lit%0d", n, d), lit[d], en[d] ? 6 : 0);
        chk({n, " pattern"}, bad, 0);
    endtask

    initial begin
        bus.A = 12'h000; bus.WD = '0; bus.WE = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rel blank", {hex, hex_dot, hex_sel}, 12'hFFF);
        @(negedge clk);
        chk("rel first", {hex, hex_dot, hex_sel}, {7'h40, 1'b1, 4'hE});
        rd("rst value", BASE, 32'h0);
        rd("rst ctrl", BASE + 12'd4, 32'h0F0);
        rd("rst raw", BASE + 12'd8, 32'h0);

        wr(BASE, 32'hABCD_1234);
        rd("value rb", BASE, 32'h1234);
        sweep("decode", 4'hF, 7'h19, 7'h30, 7'h24, 7'h79, 4'h0);

        wr(BASE + 12'd4, 32'h0000_0051);
        rd("ctrl rb", BASE + 12'd4, 32'h51);
        sweep("enables", 4'h5, 7'h19, 7'h30, 7'h24, 7'h79, 4'h1);

`ifdef SEVSEG_RAW_MODE_EN
        wr(BASE + 12'd8, 32'h0000_007F);
        wr(BASE + 12'd4, 32'h0000_01F0);
        rd("raw rb", BASE + 12'd8, 32'h7F);
        rd("ctrl raw rb", BASE + 12'd4, 32'h1F0);
        sweep("raw", 4'hF, 7'h00, 7'h7F, 7'h7F, 7'h7F, 4'h0);
`else
        wr(BASE + 12'd4, 32'h0000_01F0);
        wr(BASE + 12'd8, 32'h0000_00FF);
        rd("ctrl norawsel", BASE + 12'd4, 32'h0F0);
        rd("raw absent", BASE + 12'd8, 32'h0);
        sweep("hexonly", 4'hF, 7'h19, 7'h30, 7'h24, 7'h79, 4'h0);
`endif

        wr(BASE + 12'd1, 32'h0000_FFFF);
        wr(BASE + 12'd12, 32'h0000_FFFF);
        rd("value kept", BASE, 32'h1234);
        rd("unaligned rd", BASE + 12'd1, 32'h0);
        rd("beyond rd", BASE + 12'd12, 32'h0);

        @(negedge clk);
        bus.A = BASE; bus.WD = 32'h0000_FFFF; bus.WE = 1'b1;
        #1 chk("rd old", bus.RD, 32'h1234);
        @(posedge clk);
        #1 chk("rd new", bus.RD, 32'hFFFF);
        @(negedge clk);
        bus.WE = 1'b0;

        for (int i = 0; i < 64 && hex_sel == 4'hF; i++) @(negedge clk);
        chk("lit before rst", {31'h0, hex_sel != 4'hF}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("async rst", {hex, hex_dot, hex_sel}, 12'hFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rerel blank", {hex, hex_dot, hex_sel}, 12'hFFF);
        @(negedge clk);
        chk("rerel first", {hex, hex_dot, hex_sel}, {7'h40, 1'b1, 4'hE});
        rd("rerst value", BASE, 32'h0);
        rd("rerst ctrl", BASE + 12'd4, 32'h0F0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
